// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and types for the 16-bit pipeline
//
// Purpose: opcode encoding shared with decode, fetch-stage state type and
//          the special instruction words fetch has to recognise or emit.
// Ports:   none (package).
package cpu_pkg;

  // Bubble inserted whenever fetch has nothing valid for decode (opcode F).
  localparam logic [15:0] NOP_INSTR = 16'hF000;
  // Halt shares the FLUSH opcode; the full word distinguishes it.
  localparam logic [15:0] HLT_INSTR = 16'hFFFF;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_LUI   = 4'h7,
    OP_ADDI  = 4'h8,
    OP_LW    = 4'h9,
    OP_SW    = 4'hA,
    OP_BEQ   = 4'hB,
    OP_BNE   = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_FLUSH = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DROP  = 2'd2,
    IF_HALT  = 2'd3
  } if_state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word == HLT_INSTR;
  endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// rtl/if_redirect_mux.sv - priority select of the fetch redirect target
//
// Purpose: picks the control-flow target for fetch. Return is oldest in the
//          pipe, then branch, then call, so the oldest redirect wins.
// Ports:
//   ret_en/ret_target     return resolved at WB
//   br_taken/br_target    taken branch from EX/MEM
//   call_en/call_target   call from decode
//   call_allow            0 masks the call (it is younger than a halt)
//   redir                 some redirect is active this cycle
//   redir_pc              selected target
module if_redirect_mux
(
  input  logic        ret_en,
  input  logic [15:0] ret_target,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        call_en,
  input  logic [15:0] call_target,
  input  logic        call_allow,
  output logic        redir,
  output logic [15:0] redir_pc
);

  always_comb begin
    redir    = 1'b1;
    redir_pc = ret_target;
    if (ret_en) begin
      redir_pc = ret_target;
    end else if (br_taken) begin
      redir_pc = br_target;
    end else if (call_en && call_allow) begin
      redir_pc = call_target;
    end else begin
      redir    = 1'b0;
      redir_pc = 16'h0000;
    end
  end

endmodule

// File: rtl/if_slice.sv
// rtl/if_slice.sv - instruction-fetch stage of the 16-bit pipeline
//
// Purpose: owns the PC, runs a variable-latency instruction-memory handshake,
//          applies branch/call/return redirects, holds the fetched word while
//          decode stalls and stops on HLT. Emits NOP_INSTR as a bubble.
// Optional feature: define IF_PERF_CNT_EN to add saturating perf counters.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall                    decode hazard: hold PC and outputs
//   call_en/call_target      call redirect from decode
//   br_taken/br_target       branch redirect from EX/MEM
//   ret_en/ret_target        return redirect from WB
//   imem_req/imem_addr       fetch request, address stable until imem_rdy
//   imem_rdy/imem_data       memory response
//   PC_inc/instr             address of instr + 1, instruction to decode
//   halted                   HLT fetched, fetch stopped
//   fetch_cnt/stall_cnt/redir_cnt  perf counters (IF_PERF_CNT_EN only)
module if_slice
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        call_en,
  input  logic [15:0] call_target,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        ret_en,
  input  logic [15:0] ret_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] PC_inc,
  output logic [15:0] instr,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [15:0] redir_cnt,
`endif
  output logic        halted
);

  if_state_t   state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] pend_pc, pend_nxt;
  logic [15:0] hold_instr;
  logic        hold_valid, hold_nxt;

  logic        redir;
  logic [15:0] redir_pc;
  logic        word_ok, word_hlt, deliver;

  // A call is younger than the halt that got us here, so only return and
  // branch can wake a halted fetch.
  if_redirect_mux u_redirect_mux (
    .ret_en      (ret_en),
    .ret_target  (ret_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .call_en     (call_en),
    .call_target (call_target),
    .call_allow  (state != IF_HALT),
    .redir       (redir),
    .redir_pc    (redir_pc)
  );

  // A returning word is usable only for a live (not discarded) request with
  // no redirect overriding it this cycle.
  always_comb begin
    word_ok  = imem_rdy && !redir &&
               ((state == IF_FETCH && !hold_valid) || state == IF_WAIT);
    word_hlt = word_ok && is_halt(imem_data);
    deliver  = word_ok && !word_hlt;
  end

  assign imem_addr = pc;
  assign PC_inc    = pc + 16'd1;
  assign halted    = (state == IF_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IF_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IF_FETCH: begin
        if (!hold_valid) begin
          if (redir)         state_nxt = imem_rdy ? IF_FETCH : IF_DROP;
          else if (word_hlt) state_nxt = IF_HALT;
          else if (!imem_rdy) state_nxt = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (redir)         state_nxt = IF_DROP;
        else if (word_hlt) state_nxt = IF_HALT;
        else if (imem_rdy) state_nxt = IF_FETCH;
      end
      IF_DROP: begin
        if (imem_rdy) state_nxt = IF_FETCH;
      end
      IF_HALT: begin
        if (redir) state_nxt = IF_FETCH;
      end
      default: state_nxt = IF_FETCH;
    endcase
  end

  // While a request is outstanding the PC keeps presenting its address; the
  // redirect target waits in pend_pc until the stale response has drained.
  always_comb begin
    imem_req = 1'b0;
    instr    = NOP_INSTR;
    pc_nxt   = pc;
    pend_nxt = pend_pc;
    hold_nxt = hold_valid;
    case (state)
      IF_FETCH: begin
        if (hold_valid) begin
          if (redir) begin
            pc_nxt   = redir_pc;
            hold_nxt = 1'b0;
          end else begin
            instr = hold_instr;
            if (!stall) begin
              pc_nxt   = pc + 16'd1;
              hold_nxt = 1'b0;
            end
          end
        end else begin
          imem_req = 1'b1;
          if (redir) begin
            if (imem_rdy) pc_nxt   = redir_pc;
            else          pend_nxt = redir_pc;
          end
        end
      end
      IF_WAIT: begin
        imem_req = 1'b1;
        if (redir) pend_nxt = redir_pc;
      end
      IF_DROP: begin
        imem_req = 1'b1;
        if (redir)    pend_nxt = redir_pc;
        if (imem_rdy) pc_nxt   = pend_nxt;
      end
      IF_HALT: begin
        if (redir) pc_nxt = redir_pc;
      end
      default: ;
    endcase
    if (deliver) begin
      instr = imem_data;
      if (stall) hold_nxt = 1'b1;
      else       pc_nxt   = pc + 16'd1;
    end
    if (!rst) begin
      imem_req = 1'b0;
      instr    = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      pend_pc    <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      pend_pc    <= pend_nxt;
      hold_valid <= hold_nxt;
      if (deliver && stall) hold_instr <= imem_data;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      redir_cnt <= 16'd0;
    end else begin
      if (deliver && imem_data != NOP_INSTR && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (redir && redir_cnt != 16'hFFFF)
        redir_cnt <= redir_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_slice.sv
// tb/tb_if_slice.sv - directed self-checking bench for if_slice
module tb_if_slice;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        call_en;
  logic [15:0] call_target;
  logic        br_taken;
  logic [15:0] br_target;
  logic        ret_en;
  logic [15:0] ret_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] PC_inc;
  logic [15:0] instr;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [15:0] redir_cnt;
`endif

  logic [15:0] mem [0:511];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 16'd512) ? mem[imem_addr[8:0]] : 16'h0000;

  if_slice dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .call_en     (call_en),
    .call_target (call_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .ret_en      (ret_en),
    .ret_target  (ret_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .PC_inc      (PC_inc),
    .instr       (instr),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
    .redir_cnt   (redir_cnt),
`endif
    .halted      (halted)
  );

  task automatic idle();
    stall = 1'b0; call_en = 1'b0; br_taken = 1'b0; ret_en = 1'b0;
    call_target = 16'h0000; br_target = 16'h0000; ret_target = 16'h0000;
  endtask

  // Leaves the bench at a falling edge with reset released, PC at 0.
  task automatic do_reset();
    rst = 1'b0; idle(); imem_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); imem_rdy = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", instr, NOP); end
    checks++; if (PC_inc !== 16'h0001) begin errors++; $display("FAIL rst_pcinc: got %h expected 0001", PC_inc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h expected 0000", imem_addr); end
    @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] e;
    do_reset();
    imem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = 16'h0123 + i[15:0];
      checks++; if (imem_addr !== i[15:0]) begin errors++; $display("FAIL zw_addr[%0d]: got %h expected %h", i, imem_addr, i[15:0]); end
      checks++; if (PC_inc !== i[15:0] + 16'd1) begin errors++; $display("FAIL zw_pcinc[%0d]: got %h expected %h", i, PC_inc, i[15:0] + 16'd1); end
      checks++; if (instr !== e) begin errors++; $display("FAIL zw_instr[%0d]: got %h expected %h", i, instr, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_two_cycle();
    logic [15:0] ea, ei;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      imem_rdy = (k % 3 == 2);
      #1;
      ea = 16'(k / 3);
      ei = imem_rdy ? 16'h0123 + ea : NOP;
      checks++; if (imem_addr !== ea) begin errors++; $display("FAIL tc_addr[%0d]: got %h expected %h", k, imem_addr, ea); end
      checks++; if (instr !== ei) begin errors++; $display("FAIL tc_instr[%0d]: got %h expected %h", k, instr, ei); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL tc_req[%0d]: got %b expected 1", k, imem_req); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    imem_rdy = 1'b0;
    @(negedge clk);
    br_taken = 1'b1; br_target = 16'h0040; #1;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL br_wait_instr: got %h expected %h", instr, NOP); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL br_wait_addr: got %h expected 0000", imem_addr); end
    @(negedge clk);
    br_taken = 1'b0; imem_rdy = 1'b1; #1;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL br_drop_instr: got %h expected %h", instr, NOP); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL br_drop_addr: got %h expected 0000", imem_addr); end
    @(negedge clk); #1;
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL br_tgt_addr: got %h expected 0040", imem_addr); end
    checks++; if (instr !== 16'h0163) begin errors++; $display("FAIL br_tgt_instr: got %h expected 0163", instr); end
    checks++; if (PC_inc !== 16'h0041) begin errors++; $display("FAIL br_tgt_pcinc: got %h expected 0041", PC_inc); end
  endtask

  task automatic test_call_ret();
    do_reset();
    imem_rdy = 1'b1;
    call_en = 1'b1; call_target = 16'h0050;
    ret_en = 1'b1; ret_target = 16'h0100; #1;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL cr_instr: got %h expected %h", instr, NOP); end
    @(negedge clk);
    idle(); #1;
    checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL cr_addr: got %h expected 0100", imem_addr); end
    checks++; if (instr !== 16'h0223) begin errors++; $display("FAIL cr_tgt_instr: got %h expected 0223", instr); end
  endtask

  task automatic test_stall();
    mem[5] = 16'h1234;
    do_reset();
    imem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    stall = 1'b1; #1;
    checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL st_instr0: got %h expected 1234", instr); end
    checks++; if (PC_inc !== 16'h0006) begin errors++; $display("FAIL st_pcinc0: got %h expected 0006", PC_inc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_req0: got %b expected 1", imem_req); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL st_instr[%0d]: got %h expected 1234", i, instr); end
      checks++; if (PC_inc !== 16'h0006) begin errors++; $display("FAIL st_pcinc[%0d]: got %h expected 0006", i, PC_inc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d]: got %b expected 0", i, imem_req); end
      checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL st_addr[%0d]: got %h expected 0005", i, imem_addr); end
    end
    @(negedge clk);
    stall = 1'b0; #1;
    checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL st_release_instr: got %h expected 1234", instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_release_req: got %b expected 0", imem_req); end
    @(negedge clk); #1;
    checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL st_next_addr: got %h expected 0006", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_next_req: got %b expected 1", imem_req); end
    checks++; if (instr !== 16'h0129) begin errors++; $display("FAIL st_next_instr: got %h expected 0129", instr); end
    mem[5] = 16'h0128;
  endtask

  task automatic test_halt();
    mem[9] = 16'hFFFF;
    do_reset();
    imem_rdy = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #1;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL hlt_fetch_instr: got %h expected %h", instr, NOP); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_fetch_halted: got %b expected 0", halted); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_halted: got %b expected 1", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_req: got %b expected 0", imem_req); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL hlt_instr: got %h expected %h", instr, NOP); end
    checks++; if (imem_addr !== 16'h0009) begin errors++; $display("FAIL hlt_pc: got %h expected 0009", imem_addr); end
    call_en = 1'b1; call_target = 16'h0050;
    @(negedge clk);
    idle(); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_call_ignored: got %b expected 1", halted); end
    br_taken = 1'b1; br_target = 16'h0009;
    @(negedge clk);
    idle(); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_br_exit: got %b expected 0", halted); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hlt_br_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 16'h0009) begin errors++; $display("FAIL hlt_br_addr: got %h expected 0009", imem_addr); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_rehalt: got %b expected 1", halted); end
    rst = 1'b0; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_rst_halted: got %b expected 0", halted); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL hlt_rst_pc: got %h expected 0000", imem_addr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_rst_req: got %b expected 0", imem_req); end
    mem[9] = 16'h012C;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0123 + i[15:0];
    rst = 1'b0; idle(); imem_rdy = 1'b0;
    test_reset();
    test_zero_wait();
    test_two_cycle();
    test_branch_wait();
    test_call_ret();
    test_stall();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_slice.md
# if_slice

Instruction-fetch stage of the 5-stage 16-bit pipeline; sits directly upstream of the decode stage and feeds it `PC_inc` and `instr` each cycle. Owns the PC register, a variable-latency instruction-memory handshake, control-flow redirection (branch, call, return), decode-stall hold and halt detection. Emits the FLUSH encoding as a bubble whenever no valid instruction is available.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `NOP_INSTR`, 16'hF000, bubble driven on `instr` (opcode F, FLUSH)
- `HLT_INSTR`, 16'hFFFF, halt encoding
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `stall`  in  1  decode hazard; hold PC and outputs
- `call_en`  in  1  decode-stage Call; redirect to `call_target`
- `call_target`  in  16  `{PC[15:12], addr12}` from decode
- `br_taken`  in  1  resolved taken branch from EX/MEM
- `br_target`  in  16  branch target
- `ret_en`  in  1  return resolved at WB
- `ret_target`  in  16  return address popped from stack
- `imem_req`  out  1  fetch request
- `imem_addr`  out  16  fetch address, stable while `imem_req` && !`imem_rdy`
- `imem_rdy`  in  1  `imem_data` valid this cycle
- `imem_data`  in  16  fetched instruction
- `PC_inc`  out  16  address of `instr` + 1
- `instr`  out  16  instruction to decode, or `NOP_INSTR`
- `halted`  out  1  HLT fetched; fetch stopped

## Operation
- States: FETCH, WAIT, DROP, HALT. Registers: `pc`, `pend_pc`, `hold_instr`, `hold_valid`.
- Redirect priority: `ret_en` > `br_taken` > `call_en`; any redirect overrides `stall`. Chosen target = `redir_pc`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_rdy` same cycle, `instr`=`imem_data`, `PC_inc`=`pc`+1, `pc`<=`pc`+1 (unless stall/redirect); else -> WAIT.
- WAIT: request held, address stable, `instr`=NOP. On `imem_rdy` deliver as in FETCH, -> FETCH.
- Redirect in FETCH: `instr`=NOP this cycle; `pc`<=`redir_pc`; if `imem_rdy` was low, -> DROP with `pend_pc`<=`redir_pc`.
- Redirect in WAIT: `pend_pc`<=`redir_pc`, -> DROP. Redirect in DROP: `pend_pc` overwritten.
- DROP: outstanding request held until `imem_rdy`; data discarded, `instr`=NOP; then `pc`<=`pend_pc`, -> FETCH.
- Stall (no redirect): `pc` unchanged; delivered instruction captured in `hold_instr`/`hold_valid`; `instr`/`PC_inc` replay held value every stalled cycle; no new request while `hold_valid`. Stall drop -> held value consumed, `pc`<=`pc`+1.
- HLT: when delivered word == `HLT_INSTR` (not discarded, no redirect): `instr`=NOP, `pc` frozen, -> HALT, `halted`=1. HALT left only by `ret_en`/`br_taken` (older in-flight redirect) -> DROP/FETCH, or reset.
- PC arithmetic 16-bit, wraps 16'hFFFF -> 16'h0000.

## Timing
- Reset: `pc`=`RESET_PC`, state FETCH, `imem_req`=0 during reset, `instr`=NOP, `PC_inc`=`RESET_PC`+1, `halted`=0, `hold_valid`=0, counters 0.
- First request in first cycle after reset release.
- Zero-wait memory: one instruction per cycle, `instr` combinational from `imem_data`; decode registers it.
- Redirect-to-fetch latency: target on `imem_addr` next cycle (FETCH) or cycle after `imem_rdy` (DROP).
- Reset mid-WAIT/DROP: state abandoned; first post-reset `imem_rdy` from stale request ignored only if memory is reset together (system requirement).

## Configuration
- `IF_PERF_CNT_EN` defined: outputs `fetch_cnt` (32, delivered non-NOP instructions), `stall_cnt` (32, cycles with `stall`), `redir_cnt` (16, redirects); saturating. Undefined: ports and counters absent, no other behaviour change.

## Structure
- Shared package `cpu_pkg`: opcode enum (same encoding as decode), `if_state_t`, `NOP_INSTR`, `HLT_INSTR`.
- One sub-module `if_redirect_mux`: priority select of `redir_pc` and redirect flag.

## Test plan
- Zero-wait run from reset: `imem_rdy`=1, words 16'h0123.. -> `imem_addr` 0,1,2,3; `PC_inc` 1,2,3,4; `instr` matches.
- Two-cycle memory: `imem_rdy` every 3rd cycle -> 2 NOP cycles per instr, `imem_addr` stable across WAIT.
- `br_taken`=1, `br_target`=16'h0040 during WAIT -> stale word discarded (NOP), next `imem_addr`=16'h0040.
- `call_en` and `ret_en` same cycle, `ret_target`=16'h0100 -> next fetch 16'h0100.
- `stall` high 3 cycles after word 16'h1234 at pc 5 -> `instr`=16'h1234, `PC_inc`=6 held; no new request; then pc 6 fetched.
- Fetch 16'hFFFF at pc 9 -> `halted`=1, `instr`=NOP, `imem_req`=0; `rst` low -> `pc`=0, `halted`=0.
